// File: rtl/wb_regfile_if.sv
// Writeback-stage bus for the register file: MEM/WB inputs, read ports, status.
interface wb_regfile_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] memoryOut_MW;
    logic [DATA_W-1:0] ALUOut_MW;
    logic [DATA_W-1:0] PC2_MW;
    logic              compareResult_MW;
    logic [1:0]        regWriteDataSel_MW;
    logic              regWriteEnable_MW;
    logic [2:0]        regWriteNum_MW;
    logic              halt_MW;
    logic [2:0]        readReg1Num;
    logic [2:0]        readReg2Num;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] writeData_WB;
    logic              halted;
    logic [15:0]       retireCount;

    // The pipeline drives writeback requests and read addresses.
    modport master (
        output memoryOut_MW, ALUOut_MW, PC2_MW, compareResult_MW,
               regWriteDataSel_MW, regWriteEnable_MW, regWriteNum_MW, halt_MW,
               readReg1Num, readReg2Num,
        input  readData1, readData2, writeData_WB, halted, retireCount
    );

    // The register file consumes requests and returns data and status.
    modport slave (
        input  memoryOut_MW, ALUOut_MW, PC2_MW, compareResult_MW,
               regWriteDataSel_MW, regWriteEnable_MW, regWriteNum_MW, halt_MW,
               readReg1Num, readReg2Num,
        output readData1, readData2, writeData_WB, halted, retireCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-stage register file: source mux, two bypassed read ports,
// sticky halt FSM and a saturating retired-write counter.
module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [15:0]       retire_count;
    logic              is_halted;
    logic              wen_eff;
    logic              bypass1;
    logic              bypass2;

    assign is_halted = (state == HALTED);

    // A halt in writeback, or an already halted core, suppresses the write.
    assign wen_eff = bus.regWriteEnable_MW & ~is_halted & ~bus.halt_MW;

    // Select the writeback value from the four pipeline sources.
    always_comb begin
        write_data = '0;
        unique case (bus.regWriteDataSel_MW)
            2'b00:   write_data = bus.memoryOut_MW;
            2'b01:   write_data = bus.ALUOut_MW;
            2'b10:   write_data = bus.PC2_MW;
            default: write_data = {{(DATA_W-1){1'b0}}, bus.compareResult_MW};
        endcase
    end

    // Register array; R0 is an ordinary register, every entry clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wen_eff) begin
            regs[bus.regWriteNum_MW] <= write_data;
        end
    end

    // Count committed writes, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count <= '0;
        end else if (wen_eff && (retire_count != 16'hFFFF)) begin
            retire_count <= retire_count + 16'd1;
        end
    end

    // Halt FSM: once HALTED only a reset brings the core back to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (bus.halt_MW) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // Read ports see a same-cycle write before it lands in the array.
    always_comb begin
        bypass1    = wen_eff && (bus.readReg1Num == bus.regWriteNum_MW);
        bypass2    = wen_eff && (bus.readReg2Num == bus.regWriteNum_MW);
        read_data1 = bypass1 ? write_data : regs[bus.readReg1Num];
        read_data2 = bypass2 ? write_data : regs[bus.readReg2Num];
    end

    assign bus.readData1    = read_data1;
    assign bus.readData2    = read_data2;
    assign bus.writeData_WB = write_data;
    assign bus.halted       = is_halted;
    assign bus.retireCount  = retire_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic clk;
    logic rst;
    int   check_count;
    int   fail_count;

    wb_regfile_if #(.DATA_W(16)) bus();

    wb_regfile #(.DATA_W(16), .NUM_REGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one writeback request plus read addresses just after a falling edge.
    task automatic applyStimulus(input logic [1:0] sel, input logic wen,
                                 input logic [2:0] num, input logic halt,
                                 input logic [15:0] data, input logic cmp,
                                 input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        bus.regWriteDataSel_MW = sel;
        bus.regWriteEnable_MW  = wen;
        bus.regWriteNum_MW     = num;
        bus.halt_MW            = halt;
        bus.memoryOut_MW       = data;
        bus.ALUOut_MW          = data;
        bus.PC2_MW             = data;
        bus.compareResult_MW   = cmp;
        bus.readReg1Num        = r1;
        bus.readReg2Num        = r2;
        #1;
    endtask

    // Take one rising edge, then return to a bubble.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.regWriteEnable_MW = 1'b0;
        bus.halt_MW           = 1'b0;
        #1;
    endtask

    task automatic readPorts(input logic [2:0] r1, input logic [2:0] r2);
        bus.readReg1Num = r1;
        bus.readReg2Num = r2;
        #1;
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        bus.memoryOut_MW       = '0;
        bus.ALUOut_MW          = '0;
        bus.PC2_MW             = '0;
        bus.compareResult_MW   = 1'b0;
        bus.regWriteDataSel_MW = 2'b00;
        bus.regWriteEnable_MW  = 1'b0;
        bus.regWriteNum_MW     = 3'd0;
        bus.halt_MW            = 1'b0;
        bus.readReg1Num        = 3'd0;
        bus.readReg2Num        = 3'd0;
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_halted", {15'b0, bus.halted}, 16'h0000);
        checkOutput("reset_retire", bus.retireCount, 16'h0000);
        checkOutput("reset_rd1", bus.readData1, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ALU write to R3, bypass visible before the edge
        applyStimulus(2'b01, 1'b1, 3'd3, 1'b0, 16'h1234, 1'b0, 3'd3, 3'd0);
        checkOutput("alu_bypass_rd1", bus.readData1, 16'h1234);
        checkOutput("alu_no_bypass_rd2", bus.readData2, 16'h0000);
        tick();
        readPorts(3'd3, 3'd0);
        checkOutput("alu_reg3", bus.readData1, 16'h1234);
        checkOutput("alu_retire", bus.retireCount, 16'h0001);

        // Load write to R5 with both ports bypassed
        applyStimulus(2'b00, 1'b1, 3'd5, 1'b0, 16'hBEEF, 1'b0, 3'd5, 3'd5);
        checkOutput("dual_bypass_rd1", bus.readData1, 16'hBEEF);
        checkOutput("dual_bypass_rd2", bus.readData2, 16'hBEEF);
        checkOutput("mem_wdata", bus.writeData_WB, 16'hBEEF);
        tick();
        readPorts(3'd5, 3'd3);
        checkOutput("mem_reg5", bus.readData1, 16'hBEEF);
        checkOutput("mem_keep_reg3", bus.readData2, 16'h1234);
        checkOutput("mem_retire", bus.retireCount, 16'h0002);

        // Compare result into R2, link value into R7
        applyStimulus(2'b11, 1'b1, 3'd2, 1'b0, 16'hFFFF, 1'b1, 3'd0, 3'd0);
        checkOutput("cmp_wdata", bus.writeData_WB, 16'h0001);
        tick();
        applyStimulus(2'b10, 1'b1, 3'd7, 1'b0, 16'h0042, 1'b0, 3'd0, 3'd0);
        checkOutput("pc2_wdata", bus.writeData_WB, 16'h0042);
        tick();
        readPorts(3'd2, 3'd7);
        checkOutput("cmp_reg2", bus.readData1, 16'h0001);
        checkOutput("pc2_reg7", bus.readData2, 16'h0042);
        checkOutput("pc2_retire", bus.retireCount, 16'h0004);

        // R0 is writable and other registers stay put
        applyStimulus(2'b01, 1'b1, 3'd0, 1'b0, 16'hA5A5, 1'b0, 3'd1, 3'd1);
        tick();
        readPorts(3'd0, 3'd1);
        checkOutput("r0_write", bus.readData1, 16'hA5A5);
        checkOutput("r1_untouched", bus.readData2, 16'h0000);
        checkOutput("r0_retire", bus.retireCount, 16'h0005);

        // Bubble: no bypass and no state change
        applyStimulus(2'b01, 1'b0, 3'd3, 1'b0, 16'h0000, 1'b0, 3'd3, 3'd3);
        checkOutput("bubble_no_bypass", bus.readData1, 16'h1234);
        tick();
        readPorts(3'd3, 3'd3);
        checkOutput("bubble_reg3", bus.readData1, 16'h1234);
        checkOutput("bubble_retire", bus.retireCount, 16'h0005);

        // Halt with its own write request, which must be dropped
        applyStimulus(2'b01, 1'b1, 3'd1, 1'b1, 16'hFFFF, 1'b0, 3'd1, 3'd1);
        checkOutput("halt_no_bypass", bus.readData1, 16'h0000);
        tick();
        readPorts(3'd1, 3'd1);
        checkOutput("halt_reg1", bus.readData1, 16'h0000);
        checkOutput("halt_flag", {15'b0, bus.halted}, 16'h0001);
        checkOutput("halt_retire", bus.retireCount, 16'h0005);

        // Writes after halting are ignored and the flag is sticky
        applyStimulus(2'b01, 1'b1, 3'd3, 1'b0, 16'h9999, 1'b0, 3'd3, 3'd5);
        checkOutput("halted_no_bypass", bus.readData1, 16'h1234);
        tick();
        readPorts(3'd3, 3'd5);
        checkOutput("halted_reg3", bus.readData1, 16'h1234);
        checkOutput("halted_reg5", bus.readData2, 16'hBEEF);
        checkOutput("halted_retire", bus.retireCount, 16'h0005);
        checkOutput("halted_sticky", {15'b0, bus.halted}, 16'h0001);

        // Asynchronous reset between edges while halted
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        readPorts(3'd3, 3'd5);
        checkOutput("areset_halted", {15'b0, bus.halted}, 16'h0000);
        checkOutput("areset_reg3", bus.readData1, 16'h0000);
        checkOutput("areset_reg5", bus.readData2, 16'h0000);
        checkOutput("areset_retire", bus.retireCount, 16'h0000);

        // Requests presented during reset have no effect
        applyStimulus(2'b01, 1'b1, 3'd4, 1'b1, 16'h7777, 1'b0, 3'd4, 3'd4);
        tick();
        readPorts(3'd4, 3'd4);
        checkOutput("inreset_reg4", bus.readData1, 16'h0000);
        checkOutput("inreset_retire", bus.retireCount, 16'h0000);
        checkOutput("inreset_halted", {15'b0, bus.halted}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Saturate the retire counter with 65535 writes, then one more
        applyStimulus(2'b01, 1'b1, 3'd6, 1'b0, 16'h0000, 1'b0, 3'd6, 3'd6);
        for (int i = 0; i < 65535; i++) begin
            bus.ALUOut_MW = i[15:0];
            @(posedge clk);
            #1;
        end
        bus.regWriteEnable_MW = 1'b0;
        #1;
        checkOutput("sat_retire_max", bus.retireCount, 16'hFFFF);
        checkOutput("sat_reg6", bus.readData1, 16'hFFFE);
        applyStimulus(2'b01, 1'b1, 3'd6, 1'b0, 16'h4321, 1'b0, 3'd6, 3'd6);
        tick();
        readPorts(3'd6, 3'd6);
        checkOutput("sat_retire_hold", bus.retireCount, 16'hFFFF);
        checkOutput("sat_last_write", bus.readData1, 16'h4321);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
